// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: store-lane alignment, byte strobes, and a req/ack
// data-memory handshake with optional timeout. Load data is formatted for write-back.
module mem_stage_lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   result_i,
  input  logic [XLEN-1:0]   Rs2_data_i,
  input  logic [XLEN-1:0]   fwd_data_i,
  input  logic              forward_load_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  output logic [XLEN/8-1:0] dmem_wstrb_o,
  input  logic              dmem_ack_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              stall_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              misalign_o,
  output logic              bus_err_o
);

  localparam int NB      = XLEN / 8;
  localparam int OFFW    = $clog2(NB);
  localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t            state, state_nx;
  logic              is_op, is_load, illegal, misaligned, bad, accept, timeout_hit;
  logic [OFFW-1:0]   off;
  logic [XLEN-1:0]   sd, wdata_nx, addr_nx, sh, load_fmt, load_q;
  logic [NB-1:0]     mask, strb_nx;
  logic [2:0]        fmt_q;
  logic [OFFW-1:0]   off_q;
  logic [CW-1:0]     cnt;
  logic              err_q;

  assign is_op   = valid_i & (MemRead_i | MemWrite_i);
  assign is_load = MemRead_i;
  assign off     = result_i[OFFW-1:0];
  assign addr_nx = {result_i[XLEN-1:OFFW], {OFFW{1'b0}}};

  // Unsupported size/sign combinations are reported as misaligned accesses.
  always_comb begin
    illegal = 1'b0;
    if (funct3_i == 3'b111) illegal = 1'b1;
    if ((XLEN == 32) && ((funct3_i == 3'b011) || (funct3_i == 3'b110))) illegal = 1'b1;
    if (!is_load && funct3_i[2]) illegal = 1'b1;
  end

  always_comb begin
    misaligned = 1'b0;
    case (funct3_i[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = result_i[0];
      2'b10:   misaligned = |result_i[1:0];
      default: misaligned = |result_i[2:0];
    endcase
  end

  assign bad    = illegal | misaligned;
  assign accept = (state == IDLE) & is_op & ~bad & ~rst;

  assign sd = forward_load_i ? fwd_data_i : Rs2_data_i;

  always_comb begin
    wdata_nx = sd;
    mask     = '1;
    case (funct3_i[1:0])
      2'b00: begin wdata_nx = {NB{sd[7:0]}};            mask = NB'(8'h01); end
      2'b01: begin wdata_nx = {(XLEN/16){sd[15:0]}};    mask = NB'(8'h03); end
      2'b10: begin wdata_nx = {(XLEN/32){sd[31:0]}};    mask = NB'(8'h0F); end
      default: begin wdata_nx = sd;                     mask = '1;         end
    endcase
  end

  assign strb_nx = is_load ? '0 : (mask << off);

  assign sh = dmem_rdata_i >> {off_q, 3'b000};

  always_comb begin
    load_fmt = sh;
    case (fmt_q[1:0])
      2'b00:   load_fmt = fmt_q[2] ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]));
      2'b01:   load_fmt = fmt_q[2] ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]));
      2'b10:   load_fmt = fmt_q[2] ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]));
      default: load_fmt = sh;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TO_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = REQ;
      REQ:     if (dmem_ack_i || timeout_hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    dmem_req_o = (state == REQ);
    stall_o    = accept | (state == REQ);
    misalign_o = (state == IDLE) & is_op & bad & ~rst;
    wb_data_o  = ((state == DONE) && !dmem_we_o) ? load_q : result_i;
    bus_err_o  = err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_wstrb_o <= '0;
      dmem_we_o    <= 1'b0;
      fmt_q        <= '0;
      off_q        <= '0;
      load_q       <= '0;
      cnt          <= '0;
      err_q        <= 1'b0;
    end else begin
      if (accept) begin
        dmem_addr_o  <= addr_nx;
        dmem_wdata_o <= is_load ? '0 : wdata_nx;
        dmem_wstrb_o <= strb_nx;
        dmem_we_o    <= ~is_load;
        fmt_q        <= funct3_i;
        off_q        <= off;
        cnt          <= '0;
      end
      // Ack has priority over an expiring timeout in the same cycle.
      if (state == REQ) begin
        if (dmem_ack_i)       load_q <= load_fmt;
        else if (timeout_hit) load_q <= '0;
        else                  cnt    <= cnt + 1'b1;
      end
      err_q <= (state == REQ) & ~dmem_ack_i & timeout_hit;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: one instance without timeout, one with TIMEOUT=4.
module tb_mem_stage_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, MemRead_i, MemWrite_i, forward_load_i, dmem_ack_i;
  logic [2:0]  funct3_i;
  logic [31:0] result_i, Rs2_data_i, fwd_data_i, dmem_rdata_i;

  logic        req0, we0, stall0, mis0, err0;
  logic [31:0] addr0, wdata0, wb0;
  logic [3:0]  strb0;
  logic        req4, we4, stall4, mis4, err4;
  logic [31:0] addr4, wdata4, wb4;
  logic [3:0]  strb4;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.XLEN(32), .TIMEOUT(0)) dut0 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .funct3_i(funct3_i), .result_i(result_i), .Rs2_data_i(Rs2_data_i), .fwd_data_i(fwd_data_i),
    .forward_load_i(forward_load_i), .dmem_req_o(req0), .dmem_we_o(we0), .dmem_addr_o(addr0),
    .dmem_wdata_o(wdata0), .dmem_wstrb_o(strb0), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .stall_o(stall0), .wb_data_o(wb0), .misalign_o(mis0), .bus_err_o(err0));

  mem_stage_lsu #(.XLEN(32), .TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .funct3_i(funct3_i), .result_i(result_i), .Rs2_data_i(Rs2_data_i), .fwd_data_i(fwd_data_i),
    .forward_load_i(forward_load_i), .dmem_req_o(req4), .dmem_we_o(we4), .dmem_addr_o(addr4),
    .dmem_wdata_o(wdata4), .dmem_wstrb_o(strb4), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .stall_o(stall4), .wb_data_o(wb4), .misalign_o(mis4), .bus_err_o(err4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] res);
    valid_i = 1'b1; MemRead_i = rd; MemWrite_i = wr; funct3_i = f3; result_i = res;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; funct3_i = 3'b000;
    result_i = '0; Rs2_data_i = '0; fwd_data_i = '0; forward_load_i = 1'b0;
    dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    tick(); tick();
    total++;
    if ({req0, we0, strb0, stall0, err0, mis0} !== 9'b0)
      $display("FAIL reset_ctrl: got %b expected 0", {req0, we0, strb0, stall0, err0, mis0});
    else passed++;
    total++;
    if ({addr0, wdata0} !== 64'h0)
      $display("FAIL reset_addr_wdata: got %h expected 0", {addr0, wdata0});
    else passed++;
    rst = 1'b0;
    tick();
    result_i = 32'h0000_0055;
    #1;
    total++;
    if (wb0 !== 32'h0000_0055) $display("FAIL idle_wb: got %h expected 00000055", wb0);
    else passed++;
    tick();
  endtask

  task automatic test_sb();
    int stalls = 0;
    set_op(1'b0, 1'b1, 3'b000, 32'h0000_1003);
    Rs2_data_i = 32'h0000_00A5;
    #1;
    if (stall0) stalls++;
    tick();
    if (stall0) stalls++;
    total++;
    if ({req0, we0, strb0} !== 6'b11_1000)
      $display("FAIL sb_req_we_strb: got %b expected 111000", {req0, we0, strb0});
    else passed++;
    total++;
    if ({addr0, wdata0} !== {32'h0000_1000, 32'hA5A5_A5A5})
      $display("FAIL sb_addr_wdata: got %h expected 00001000a5a5a5a5", {addr0, wdata0});
    else passed++;
    tick();
    dmem_ack_i = 1'b1;
    #1;
    if (stall0) stalls++;
    total++;
    if ({req0, addr0} !== {1'b1, 32'h0000_1000})
      $display("FAIL sb_hold: got %h expected 100001000", {req0, addr0});
    else passed++;
    tick();
    dmem_ack_i = 1'b0;
    #1;
    if (stall0) stalls++;
    total++;
    if (stalls !== 3) $display("FAIL sb_stall_cycles: got %0d expected 3", stalls);
    else passed++;
    total++;
    if ({req0, wb0} !== {1'b0, 32'h0000_1003})
      $display("FAIL sb_done_wb: got %h expected 000001003", {req0, wb0});
    else passed++;
    tick();
  endtask

  task automatic test_back_to_back_lh(input logic [2:0] f3, input logic [31:0] exp);
    set_op(1'b1, 1'b0, f3, 32'h0000_2002);
    #1;
    total++;
    if (stall0 !== 1'b1) $display("FAIL lh_accept_stall: got %b expected 1", stall0);
    else passed++;
    tick();
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h8001_1234;
    #1;
    total++;
    if ({req0, we0, strb0} !== 6'b10_0000)
      $display("FAIL lh_req_strb: got %b expected 100000", {req0, we0, strb0});
    else passed++;
    tick();
    dmem_ack_i = 1'b0;
    #1;
    total++;
    if ({stall0, wb0} !== {1'b0, exp})
      $display("FAIL lh_wb f3=%b: got %h expected %h", f3, {stall0, wb0}, {1'b0, exp});
    else passed++;
    tick();
  endtask

  task automatic test_sw_forward();
    set_op(1'b0, 1'b1, 3'b010, 32'h0000_0010);
    forward_load_i = 1'b1; fwd_data_i = 32'hDEAD_BEEF; Rs2_data_i = 32'h0;
    tick();
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
    #1;
    total++;
    if ({wdata0, strb0} !== {32'hDEAD_BEEF, 4'b1111})
      $display("FAIL sw_fwd: got %h expected deadbeeff", {wdata0, strb0});
    else passed++;
    tick();
    dmem_ack_i = 1'b0; forward_load_i = 1'b0;
    tick();
  endtask

  task automatic test_misalign(input logic [2:0] f3, input logic [31:0] a);
    set_op(1'b1, 1'b0, f3, a);
    #1;
    total++;
    if ({mis0, req0, stall0} !== 3'b100)
      $display("FAIL misalign f3=%b: got %b expected 100", f3, {mis0, req0, stall0});
    else passed++;
    tick();
    valid_i = 1'b0;
    #1;
    total++;
    if ({mis0, req0, stall0} !== 3'b000)
      $display("FAIL misalign_after f3=%b: got %b expected 000", f3, {mis0, req0, stall0});
    else passed++;
    tick();
  endtask

  task automatic test_timeout();
    int reqs = 0;
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0040);
    dmem_rdata_i = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (req4) reqs++;
    end
    tick();
    valid_i = 1'b0;
    #1;
    total++;
    if (reqs !== 4) $display("FAIL to_req_cycles: got %0d expected 4", reqs);
    else passed++;
    total++;
    if ({req4, err4, stall4, wb4} !== {3'b010, 32'h0})
      $display("FAIL to_done: got %h expected 200000000", {req4, err4, stall4, wb4});
    else passed++;
    total++;
    if (req0 !== 1'b1) $display("FAIL no_timeout_hold: got %b expected 1", req0);
    else passed++;
    tick();
    total++;
    if (err4 !== 1'b0) $display("FAIL to_err_pulse: got %b expected 0", err4);
    else passed++;
  endtask

  task automatic test_rst_mid_req();
    rst = 1'b1;
    #1;
    total++;
    if ({req0, stall0} !== 2'b00) $display("FAIL rst_mid_req: got %b expected 00", {req0, stall0});
    else passed++;
    tick();
    rst = 1'b0;
    tick();
    set_op(1'b1, 1'b0, 3'b100, 32'h0000_3001);
    tick();
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h0000_FF00;
    tick();
    dmem_ack_i = 1'b0; valid_i = 1'b0;
    #1;
    total++;
    if (wb0 !== 32'h0000_00FF) $display("FAIL lbu_after_rst: got %h expected 000000ff", wb0);
    else passed++;
    tick();
  endtask

  task automatic test_ack_at_limit();
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0044);
    for (int i = 0; i < 3; i++) tick();
    tick();
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
    #1;
    total++;
    if (req4 !== 1'b1) $display("FAIL ack4_req: got %b expected 1", req4);
    else passed++;
    tick();
    dmem_ack_i = 1'b0; valid_i = 1'b0;
    #1;
    total++;
    if ({err4, wb4} !== {1'b0, 32'h1234_5678})
      $display("FAIL ack4_done: got %h expected 012345678", {err4, wb4});
    else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_sb();
    test_back_to_back_lh(3'b001, 32'hFFFF_8001);
    test_back_to_back_lh(3'b101, 32'h0000_8001);
    test_sw_forward();
    test_misalign(3'b010, 32'h0000_2001);
    test_misalign(3'b011, 32'h0000_2000);
    test_timeout();
    test_rst_mid_req();
    test_ack_at_limit();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Parametrised memory-stage load/store unit for the pipelined RISC-V core. It sits between the EX/MEM and MEM/WB pipeline registers. It selects forwarded or register store data, aligns store data into byte lanes with byte strobes, and drives a request/acknowledge data-memory port with an optional timeout. It stalls the pipeline while an access is outstanding, and produces sign- or zero-extended load data or the ALU result for write-back.

## Interface

Parameters:
- `XLEN`, 32: datapath width; 32 or 64. `XLEN=64` enables LD/SD and LWU.
- `TIMEOUT`, 0: maximum number of REQ cycles to wait for `dmem_ack_i`; 0 disables the timeout.

Ports:
- `clk` in 1: clock; everything sampled on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `valid_i` in 1: the MEM-stage instruction is valid.
- `MemRead_i` in 1: the instruction is a load; it takes priority over `MemWrite_i`.
- `MemWrite_i` in 1: the instruction is a store.
- `funct3_i` in 3: access size and sign.
  - 000 byte, 001 half, 010 word, 011 double.
  - 100 byte unsigned, 101 half unsigned, 110 word unsigned.
- `result_i` in XLEN: ALU result; it is the effective address for loads and stores.
- `Rs2_data_i` in XLEN: store data taken from the register path.
- `fwd_data_i` in XLEN: load data forwarded from MEM/WB.
- `forward_load_i` in 1: when 1, store data comes from `fwd_data_i`.
- `dmem_req_o` out 1: memory request.
- `dmem_we_o` out 1: write enable.
- `dmem_addr_o` out XLEN: address with the low log2(XLEN/8) bits cleared.
- `dmem_wdata_o` out XLEN: lane-replicated store data.
- `dmem_wstrb_o` out XLEN/8: byte strobes.
- `dmem_ack_i` in 1: access complete; `dmem_rdata_i` is valid in the same cycle.
- `dmem_rdata_i` in XLEN: raw read data.
- `stall_o` out 1: freeze IF/ID/EX/MEM.
- `wb_data_o` out XLEN: write-back data.
- `misalign_o` out 1: misaligned-access pulse.
- `bus_err_o` out 1: timeout pulse.

## Operation

- FSM has three states: IDLE, REQ, DONE. Reset and any `rst` assertion force IDLE asynchronously, including mid-REQ.
- Reset values:
  - `dmem_req_o`, `dmem_we_o`, `dmem_wstrb_o` = 0.
  - `dmem_addr_o`, `dmem_wdata_o` = 0.
  - Internal load register = 0.
  - `bus_err_o` = 0.
- IDLE, and no valid memory operation: `stall_o`=0, `misalign_o`=0, `wb_data_o`=`result_i`.
- Misalignment rule: an access is misaligned when its address is not a multiple of its size (half: addr[0]≠0; word: addr[1:0]≠0; double: addr[2:0]≠0).
- IDLE, valid memory operation, misaligned:
  - `misalign_o`=1 (combinational), `stall_o`=0.
  - No request is issued; state stays IDLE.
- IDLE, valid memory operation, aligned:
  - `stall_o`=1; register address, we, wdata and wstrb; go to REQ.
- Illegal operation: funct3 011 or 110 with `XLEN=32`, or a store with funct3 ≥100, is treated as misaligned.
- REQ:
  - `dmem_req_o`=1, `stall_o`=1. Address, we, wdata and wstrb are held stable.
  - Sampled ack: capture formatted read data and go to DONE.
  - Timeout: when `TIMEOUT`≠0 and the REQ-cycle counter reaches `TIMEOUT` without an ack, go to DONE with the error flag set and the load register cleared to 0.
- DONE:
  - `stall_o`=0. `wb_data_o` = load register for a load, `result_i` for a store. `bus_err_o`=1 if the access timed out.
  - Inputs are ignored; return to IDLE unconditionally.
- Store data: `sd` = `forward_load_i` ? `fwd_data_i` : `Rs2_data_i`.
  - Byte: `sd[7:0]` replicated to every byte.
  - Half: `sd[15:0]` replicated to every half.
  - Word: `sd[31:0]` replicated to every word.
  - Double: `sd` unchanged.
- Write strobes: (2^size − 1) << addr offset, where size is the access size in bytes. Loads drive strobes = 0.
- Load formatting: shift `dmem_rdata_i` right by 8×offset, then take the low bytes of the access size. Sign-extend for funct3 000/001/010; zero-extend for 100/101/110.
- Ack while not in REQ is ignored.

## Timing

- Accepted access: cycle T is IDLE (accept) with stall=1. From T+1 the FSM is in REQ.
- An ack sampled at the end of cycle T+k moves the FSM to DONE in T+k+1, with stall=0.
- Minimum total is 3 cycles with stall high for 2 cycles; stall spans T through T+k.
- `dmem_req_o` is a registered state output; it drops in the cycle after the ack is sampled.
- Timeout: the counter resets on entry to REQ and increments on each REQ cycle without an ack. Abort happens after `TIMEOUT` REQ cycles.
- If ack and the timeout condition occur in the same cycle, the ack wins and no error is raised.
- `misalign_o` and `bus_err_o` are single-cycle pulses.
- Back-to-back accesses: the next instruction is accepted in the IDLE cycle that follows DONE.

## Test plan

- SB, `XLEN=32`, addr 0x1003, Rs2 0x000000A5, ack in the 2nd REQ cycle:
  - addr 0x1000, wdata 0xA5A5A5A5, wstrb 4'b1000, we=1.
  - stall high for 3 cycles; `wb_data_o`=0x1003 in DONE.
- LH at 0x2002 with rdata 0x80011234, ack in the 1st REQ cycle:
  - DONE `wb_data_o`=0xFFFF8001.
  - Repeat with LHU: `wb_data_o`=0x00008001.
- SW at 0x10, `forward_load_i`=1, fwd 0xDEADBEEF, Rs2 0x0:
  - wdata 0xDEADBEEF, wstrb 4'b1111.
- LW at 0x2001:
  - `misalign_o`=1 for one cycle, `dmem_req_o` stays 0, stall 0.
  - Same result for LD with `XLEN=32`.
- `TIMEOUT`=4, no ack:
  - req high for exactly 4 cycles, then DONE with `bus_err_o`=1 and load data 0; stall releases.
  - Ack in the 4th REQ cycle: no error.
- `rst` pulsed mid-REQ:
  - `dmem_req_o` and `stall_o` drop to 0 before the next edge; state is IDLE.
  - A following LBU at 0x3001 with rdata 0x0000FF00 returns 0x000000FF.
